// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / status bundle between decode and the register scoreboard.
// master = decode side, slave = scoreboard side.
interface reg_scoreboard_if #(
   parameter int STALL_W = 16
);
   logic               iss_valid;
   logic               iss_ready;
   logic [3:0]         iss_src1;
   logic               iss_use1;
   logic [3:0]         iss_src2;
   logic               iss_use2;
   logic [3:0]         iss_dst;
   logic               iss_wr;
   logic               wb_wr;
   logic [3:0]         wb_dst;
   logic               flush;
   logic [15:0]        pending;
   logic [STALL_W-1:0] stall_cnt;
   logic               sb_err;

   modport master (
      output iss_valid, iss_src1, iss_use1, iss_src2, iss_use2, iss_dst, iss_wr,
      output wb_wr, wb_dst, flush,
      input  iss_ready, pending, stall_cnt, sb_err
   );

   modport slave (
      input  iss_valid, iss_src1, iss_use1, iss_src2, iss_use2, iss_dst, iss_wr,
      input  wb_wr, wb_dst, flush,
      output iss_ready, pending, stall_cnt, sb_err
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Decode-stage hazard tracker: per-register in-flight write counters gate issue.
// Define WB_BYPASS_EN to let a source issue in the same cycle as its final writeback.
module reg_scoreboard #(
   parameter int NREG    = 16,
   parameter int CNT_W   = 2,
   parameter int STALL_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   reg_scoreboard_if.slave sb
);
   localparam int                 ID_W      = $clog2(NREG);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   logic [CNT_W-1:0]   cnt_q [NREG];
   logic [CNT_W-1:0]   cnt_d [NREG];
   logic [NREG-1:0]    pending_q, pending_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               err_q, err_d;

   logic [NREG-1:0]    busy;
   logic [NREG-1:0]    inc, dec;
   logic               iss_ready_w;
   logic               fire;

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         busy[r] = (cnt_q[r] != '0);
`ifdef WB_BYPASS_EN
         // The register file writes before it reads, so the last outstanding
         // write landing this cycle already satisfies the consumer.
         if (sb.wb_wr && (sb.wb_dst == ID_W'(r)) && (cnt_q[r] == CNT_ONE) && !sb.flush)
            busy[r] = 1'b0;
`endif
      end
   end

   // Saturation guard blocks issue instead of letting a counter overflow.
   assign iss_ready_w = !sb.flush
                     && !(sb.iss_use1 && busy[sb.iss_src1])
                     && !(sb.iss_use2 && busy[sb.iss_src2])
                     && !(sb.iss_wr && (cnt_q[sb.iss_dst] == CNT_MAX));

   assign fire = sb.iss_valid && iss_ready_w;

   // NOTE: every signal written in this always_comb gets a default value first,
   // so no path through the block can leave it unassigned and infer a latch.
   always_comb begin
      err_d   = err_q;
      stall_d = stall_q;
      for (int r = 0; r < NREG; r++) begin
         inc[r] = fire && sb.iss_wr && (sb.iss_dst == ID_W'(r));
         dec[r] = sb.wb_wr && (sb.wb_dst == ID_W'(r)) && (cnt_q[r] != '0);
         cnt_d[r] = cnt_q[r];
         if (sb.flush)
            cnt_d[r] = '0;
         else if (inc[r] && !dec[r])
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         else if (dec[r] && !inc[r])
            cnt_d[r] = cnt_q[r] - CNT_ONE;
         pending_d[r] = (cnt_d[r] != '0);
      end

      if (!sb.flush && sb.wb_wr && (cnt_q[sb.wb_dst] == '0))
         err_d = 1'b1;

      if (sb.iss_valid && !iss_ready_w && (stall_q != STALL_MAX))
         stall_d = stall_q + STALL_W'(1);
   end

   // NOTE: the counter array is real hazard state, not data storage, so every
   // entry is cleared by reset; an unreset entry would block or mis-track issue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
         pending_q <= '0;
         stall_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all state samples the pre-edge values.
         for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         pending_q <= pending_d;
         stall_q   <= stall_d;
         err_q     <= err_d;
      end
   end

   assign sb.iss_ready = iss_ready_w;
   assign sb.pending   = pending_q;
   assign sb.stall_cnt = stall_q;
   assign sb.sb_err    = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard against a count-per-register reference model.
module tb_reg_scoreboard;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   int   model_cnt [16];
   bit   model_err;
   int   model_stall;

   always #5 clk = ~clk;

   reg_scoreboard_if #(.STALL_W(16)) bus ();

   reg_scoreboard #(.NREG(16), .CNT_W(2), .STALL_W(16)) dut (
      .clk (clk),
      .rst (rst_n),
      .sb  (bus)
   );

   function automatic bit model_busy(input int r);
      bit b = (model_cnt[r] != 0);
`ifdef WB_BYPASS_EN
      if (bus.wb_wr && int'(bus.wb_dst) == r && model_cnt[r] == 1 && !bus.flush) b = 1'b0;
`endif
      return b;
   endfunction

   function automatic bit model_ready();
      bit blk = bus.flush;
      if (bus.iss_use1 && model_busy(int'(bus.iss_src1))) blk = 1'b1;
      if (bus.iss_use2 && model_busy(int'(bus.iss_src2))) blk = 1'b1;
      if (bus.iss_wr && model_cnt[bus.iss_dst] == 3) blk = 1'b1;
      return !blk;
   endfunction

   function automatic logic [15:0] model_pending();
      logic [15:0] p;
      for (int i = 0; i < 16; i++) p[i] = (model_cnt[i] != 0);
      return p;
   endfunction

   task automatic idle();
      bus.iss_valid = 0; bus.iss_src1 = 0; bus.iss_use1 = 0; bus.iss_src2 = 0;
      bus.iss_use2 = 0; bus.iss_dst = 0; bus.iss_wr = 0; bus.wb_wr = 0;
      bus.wb_dst = 0; bus.flush = 0;
   endtask

   // Advance one clock edge, applying the model's view of that edge.
   task automatic tick();
      bit rdy = model_ready();
      if (bus.iss_valid && !rdy && model_stall < 65535) model_stall++;
      if (bus.flush) begin
         for (int i = 0; i < 16; i++) model_cnt[i] = 0;
      end else begin
         if (bus.wb_wr) begin
            if (model_cnt[bus.wb_dst] == 0) model_err = 1'b1;
            else model_cnt[bus.wb_dst]--;
         end
         if (bus.iss_valid && rdy && bus.iss_wr) model_cnt[bus.iss_dst]++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) model_cnt[i] = 0;
      model_err = 0;
      model_stall = 0;
   endtask

   task automatic issue_wr(input logic [3:0] dst);
      idle();
      bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_dst = dst;
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
      bus.iss_valid = 1; bus.iss_use1 = 1; bus.iss_src1 = 5;
      #1;
      checks++; if (bus.pending !== 16'h0000) begin failures++; $display("FAIL reset_pending got=%h exp=0000", bus.pending); end
      checks++; if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cnt); end
      checks++; if (bus.sb_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.sb_err); end
      checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.iss_ready); end
      tick();
   endtask

   task automatic test_raw_stall();
      logic exp_k;
      apply_reset();
      issue_wr(4'd3);
      idle();
      bus.iss_valid = 1; bus.iss_use1 = 1; bus.iss_src1 = 3;
      #1;
      checks++; if (bus.pending !== 16'h0008) begin failures++; $display("FAIL raw_pending got=%h exp=0008", bus.pending); end
      checks++; if (bus.iss_ready !== 1'b0) begin failures++; $display("FAIL raw_blocked got=%b exp=0", bus.iss_ready); end
      tick(); tick();
      checks++; if (bus.stall_cnt !== 16'd2) begin failures++; $display("FAIL raw_stall_cnt got=%0d exp=2", bus.stall_cnt); end
      bus.wb_wr = 1; bus.wb_dst = 3;
      #1;
      exp_k = 1'b0;
`ifdef WB_BYPASS_EN
      exp_k = 1'b1;
`endif
      checks++; if (bus.iss_ready !== exp_k) begin failures++; $display("FAIL raw_wb_cycle got=%b exp=%b", bus.iss_ready, exp_k); end
      tick();
      bus.wb_wr = 0;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL raw_after_wb got=%b exp=1", bus.iss_ready); end
      checks++; if (bus.pending !== 16'h0000) begin failures++; $display("FAIL raw_pending_clr got=%h exp=0000", bus.pending); end
      checks++; if (bus.stall_cnt !== 16'(model_stall)) begin failures++; $display("FAIL raw_stall_final got=%0d exp=%0d", bus.stall_cnt, model_stall); end
      tick();
   endtask

   task automatic test_saturation();
      apply_reset();
      repeat (3) issue_wr(4'd7);
      idle();
      bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_dst = 7;
      #1;
      checks++; if (bus.iss_ready !== 1'b0) begin failures++; $display("FAIL sat_block got=%b exp=0", bus.iss_ready); end
      checks++; if (bus.pending !== 16'h0080) begin failures++; $display("FAIL sat_pending got=%h exp=0080", bus.pending); end
      bus.wb_wr = 1; bus.wb_dst = 7;
      #1;
      checks++; if (bus.iss_ready !== 1'b0) begin failures++; $display("FAIL sat_wb_cycle got=%b exp=0", bus.iss_ready); end
      tick();
      bus.wb_wr = 0;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL sat_accept got=%b exp=1", bus.iss_ready); end
      tick();
      #1;
      checks++; if (bus.iss_ready !== 1'b0) begin failures++; $display("FAIL sat_full_again got=%b exp=0", bus.iss_ready); end
      idle();
      // Three writebacks must drain the counter exactly.
      repeat (3) begin bus.wb_wr = 1; bus.wb_dst = 7; tick(); end
      idle();
      #1;
      checks++; if (bus.pending !== 16'h0000 || bus.sb_err !== 1'b0) begin failures++; $display("FAIL sat_drain got=%h/%b exp=0000/0", bus.pending, bus.sb_err); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      issue_wr(4'd2);
      idle();
      bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_dst = 2; bus.wb_wr = 1; bus.wb_dst = 2;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL simul_ready got=%b exp=1", bus.iss_ready); end
      tick();
      idle();
      #1;
      checks++; if (bus.pending !== 16'h0004 || bus.sb_err !== 1'b0) begin failures++; $display("FAIL simul_state got=%h/%b exp=0004/0", bus.pending, bus.sb_err); end
      bus.wb_wr = 1; bus.wb_dst = 2;
      tick();
      idle();
      #1;
      checks++; if (bus.pending !== 16'h0000) begin failures++; $display("FAIL simul_count_one got=%h exp=0000", bus.pending); end
   endtask

   task automatic test_spurious_wb();
      apply_reset();
      issue_wr(4'd1);
      idle();
      bus.wb_wr = 1; bus.wb_dst = 9;
      tick();
      idle();
      #1;
      checks++; if (bus.sb_err !== 1'b1) begin failures++; $display("FAIL spur_err got=%b exp=1", bus.sb_err); end
      checks++; if (bus.pending !== 16'h0002) begin failures++; $display("FAIL spur_pending got=%h exp=0002", bus.pending); end
      repeat (3) tick();
      checks++; if (bus.sb_err !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%b exp=1", bus.sb_err); end
   endtask

   task automatic test_flush();
      apply_reset();
      issue_wr(4'd1); issue_wr(4'd1); issue_wr(4'd4);
      idle();
      bus.iss_valid = 1; bus.flush = 1; bus.wb_wr = 1; bus.wb_dst = 9;
      #1;
      checks++; if (bus.iss_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", bus.iss_ready); end
      tick();
      #1;
      checks++; if (bus.stall_cnt !== 16'd1) begin failures++; $display("FAIL flush_stall got=%0d exp=1", bus.stall_cnt); end
      checks++; if (bus.pending !== 16'h0000 || bus.sb_err !== 1'b0) begin failures++; $display("FAIL flush_state got=%h/%b exp=0000/0", bus.pending, bus.sb_err); end
      // Hold a stall long enough to saturate the counter.
      bus.wb_wr = 0;
      repeat (65540) @(posedge clk);
      #1;
      checks++; if (bus.stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL stall_sat got=%h exp=FFFF", bus.stall_cnt); end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.stall_cnt !== 16'h0000 || bus.pending !== 16'h0000) begin failures++; $display("FAIL async_rst got=%h/%h exp=0000/0000", bus.stall_cnt, bus.pending); end
      idle();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [15:0] ep;
      bit er;
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         bus.iss_valid = ($urandom_range(0, 9) < 7);
         bus.iss_use1  = $urandom_range(0, 1);
         bus.iss_src1  = 4'($urandom_range(0, 4));
         bus.iss_use2  = $urandom_range(0, 1);
         bus.iss_src2  = 4'($urandom_range(0, 4));
         bus.iss_wr    = ($urandom_range(0, 9) < 6);
         bus.iss_dst   = 4'($urandom_range(0, 3));
         bus.wb_wr     = ($urandom_range(0, 9) < 5);
         bus.wb_dst    = 4'($urandom_range(0, 3));
         bus.flush     = ($urandom_range(0, 99) < 3);
         #1;
         er = model_ready();
         checks++; if (bus.iss_ready !== er) begin failures++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, bus.iss_ready, er); end
         tick();
         ep = model_pending();
         checks++; if (bus.pending !== ep) begin failures++; $display("FAIL rand_pending n=%0d got=%h exp=%h", n, bus.pending, ep); end
         checks++; if (bus.stall_cnt !== 16'(model_stall) || bus.sb_err !== model_err) begin
            failures++; $display("FAIL rand_status n=%0d got=%0d/%b exp=%0d/%b", n, bus.stall_cnt, bus.sb_err, model_stall, model_err);
         end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_raw_stall();
      test_saturation();
      test_simultaneous();
      test_spurious_wb();
      test_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Decode-stage hazard tracker that sits directly upstream of the 16x16 register file read ports. It counts in-flight writes per architectural register, which are set on instruction issue and retired by the register-file write port (WriteReg/DstReg). It asserts iss_ready only when both source operands read from the register file are current. It also exposes a pending bitmask, a stall-cycle counter and a protocol error flag.

Parameters:
NREG, 16, number of tracked registers; must be 16 to match 4-bit register IDs
CNT_W, 2, width of each per-register in-flight counter; the maximum count is 2^CNT_W-1 (3)
STALL_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  system clock; all state is updated on the rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
iss_valid  in  1  decode presents an instruction for issue
iss_ready  out  1  issue is permitted this cycle (combinational)
iss_src1  in  4  first source register ID (drives SrcReg1)
iss_use1  in  1  iss_src1 is actually read
iss_src2  in  4  second source register ID (drives SrcReg2)
iss_use2  in  1  iss_src2 is actually read
iss_dst  in  4  destination register ID
iss_wr  in  1  the instruction will write iss_dst
wb_wr  in  1  register-file write strobe; same signal as the register file's WriteReg
wb_dst  in  4  register-file write ID; same signal as DstReg
flush  in  1  squash all in-flight instructions
pending  out  16  bit r = 1 when cnt[r] != 0 (registered)
stall_cnt  out  STALL_W  count of cycles with iss_valid=1 and iss_ready=0
sb_err  out  1  sticky flag: a writeback arrived for a register whose counter was 0

Behaviour:
- Reset (rst=0, asynchronous): all cnt[r]=0, pending=0, stall_cnt=0, sb_err=0. iss_ready then evaluates to 1 unless flush=1. Reset mid-operation discards all tracking immediately.
- State: 16 counters, each CNT_W bits wide.
- Busy rule: busy(r) = (cnt[r] != 0). See the optional feature for the bypass variant.
- iss_ready = !flush & !(iss_use1 & busy(iss_src1)) & !(iss_use2 & busy(iss_src2)) & !(iss_wr & cnt[iss_dst]==MAX).
  - The last term is the saturation guard: issue blocks rather than overflowing the counter.
- iss_ready is independent of iss_valid; there is no combinational path from iss_valid to iss_ready.
- Issue fires when iss_valid & iss_ready.
- Counter update each edge, per register r:
  - inc = issue fires & iss_wr & (iss_dst == r)
  - dec = wb_wr & (wb_dst == r) & (cnt[r] != 0)
  - inc & dec: cnt unchanged (simultaneous issue and retire to the same register)
  - inc only: cnt+1
  - dec only: cnt-1
- A writeback with cnt[wb_dst]==0 has no counter effect and sets sb_err=1. sb_err is cleared only by reset.
- flush=1: at the next edge all cnt are cleared to 0 and any writeback that cycle is ignored (no sb_err). iss_ready=0 during the flush cycle, so nothing is issued.
- Latency: counter and pending changes are visible 1 cycle after the causing edge. pending is a registered decode of cnt.
- A source equal to the destination (e.g. R3 <- R3+R1) checks the source against the pre-issue count, then increments.
- stall_cnt increments on every cycle with iss_valid & !iss_ready, including flush cycles. It saturates at all-ones and does not wrap.
- Register 0 is tracked like any other register; the register file does not hardwire it.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: busy(r) = cnt[r]!=0 & !(wb_wr & wb_dst==r & cnt[r]==1 & !flush). A source whose last in-flight write is being written back this cycle is treated as ready, because the register file delivers the write-before-read value in the same cycle.
- Not defined: busy(r) = cnt[r]!=0, so the consumer issues one cycle after the writeback edge.
- Counter update rules are identical in both builds.

Test Plan:
- Reset then idle: rst low for 2 cycles, then high -> pending=16'h0000, stall_cnt=0, sb_err=0, iss_ready=1 for iss_valid=1 with iss_use1=1, iss_src1=5.
- RAW stall: issue iss_wr=1, iss_dst=3; next cycle iss_valid=1, iss_use1=1, iss_src1=3 -> pending=16'h0008, iss_ready=0, stall_cnt increments each cycle. Drive wb_wr=1, wb_dst=3 at cycle k -> iss_ready=1 at cycle k+1 without WB_BYPASS_EN, at cycle k with it.
- Saturation: issue 3 writes to R7 with no writeback -> cnt[7]=3; a 4th issue with iss_dst=7 -> iss_ready=0. A single wb to R7 -> the 4th issue is accepted the next cycle with cnt[7] back at 3.
- Simultaneous: cnt[2]=1, issue iss_dst=2 and wb_dst=2 in the same cycle -> cnt[2] stays 1, pending[2]=1, sb_err=0.
- Spurious writeback: wb_wr=1, wb_dst=9 with cnt[9]=0 -> sb_err=1 and it remains 1; pending unchanged.
- Flush: cnt[1]=2, cnt[4]=1, flush=1 for 1 cycle with iss_valid=1 -> iss_ready=0 during flush, stall_cnt+1, pending=16'h0000 after the edge; async rst pulse mid-cycle with stall_cnt=16'hFFFF -> stall_cnt=0 immediately.
